ips2l_uart_status_responder: RTL and testbench



---
 rtl/ips2l_uart_status_pkg.sv | 14 +
 rtl/ips2l_uart_status_responder_if.sv | 23 ++
 rtl/ips2l_uart_evt_cnt.sv | 24 ++
 rtl/ips2l_uart_status_responder.sv | 126 ++++++++++++
 tb/tb_ips2l_uart_status_responder.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ips2l_uart_status_pkg.sv
// Shared constants for the UART status responder: address map bases and read FSM states.
package ips2l_uart_status_pkg;

  localparam logic [7:0] ST_BASE  = 8'h00;
  localparam logic [7:0] EVT_BASE = 8'h10;
  localparam logic [7:0] ID_ADDR  = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/ips2l_uart_status_responder_if.sv
// Register-read handshake between the UART control block (master) and the status responder (slave).
interface ips2l_uart_status_responder_if;

  // Four-phase level handshake: master raises read_req with uart_rd_addr stable and holds both
  // until read_ack is seen high; status_bus is valid while read_ack is high; master then drops
  // read_req and the slave drops read_ack. rd_busy marks capture..ack-fall.
  logic        read_req;
  logic [7:0]  uart_rd_addr;
  logic        read_ack;
  logic [31:0] status_bus;
  logic        rd_busy;

  modport master (
    output read_req, uart_rd_addr,
    input  read_ack, status_bus, rd_busy
  );

  modport slave (
    input  read_req, uart_rd_addr,
    output read_ack, status_bus, rd_busy
  );

endinterface

// File: rtl/ips2l_uart_evt_cnt.sv
// Saturating 32-bit event counter; a clear in the same cycle as an increment leaves it at 1.
module ips2l_uart_evt_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_inc,
  input  logic        i_clr,
  output logic [31:0] o_cnt
);

  logic [31:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= {31'd0, i_inc};
    end else if (i_inc && (r_cnt != 32'hFFFF_FFFF)) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ips2l_uart_status_responder.sv
// UART status responder: snapshots a status word / event counter / ID on read_req and returns it
// with read_ack after RD_LAT cycles. Define UART_STATUS_CLR_ON_RD_EN for clear-on-read counters.
module ips2l_uart_status_responder
  import ips2l_uart_status_pkg::*;
#(
  parameter int          NUM_ST       = 8,
  parameter int          NUM_EVT      = 4,
  parameter int          RD_LAT       = 2,
  parameter logic [31:0] ID_VAL       = 32'h5043_0001,
  parameter logic [31:0] UNMAPPED_VAL = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ips2l_uart_status_responder_if.slave bus,
  input  logic [NUM_ST*32-1:0]     st_in,
  input  logic [NUM_EVT-1:0]       evt_in,
  output rd_state_e                o_dbg_state
);

  localparam logic [3:0] LAT_LOAD = 4'(RD_LAT - 1);

  rd_state_e          r_state;
  logic [3:0]         r_lat_cnt;
  logic [31:0]        r_snap;
  logic [31:0]        r_status;
  logic               r_ack;
  logic               r_busy;
  logic [31:0]        w_sel;
  logic [NUM_EVT-1:0] w_clr;
  logic [31:0]        w_cnt [NUM_EVT];

  for (genvar g = 0; g < NUM_EVT; g++) begin : g_evt
    ips2l_uart_evt_cnt u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (evt_in[g]),
      .i_clr (w_clr[g]),
      .o_cnt (w_cnt[g])
    );
  end

  always_comb begin
    w_sel = UNMAPPED_VAL;
    if (bus.uart_rd_addr == ID_ADDR) w_sel = ID_VAL;
    for (int k = 0; k < NUM_ST; k++) begin
      if (bus.uart_rd_addr == ST_BASE + 8'(k)) w_sel = st_in[k*32 +: 32];
    end
    for (int k = 0; k < NUM_EVT; k++) begin
      if (bus.uart_rd_addr == EVT_BASE + 8'(k)) w_sel = w_cnt[k];
    end
  end

`ifdef UART_STATUS_CLR_ON_RD_EN
  logic [NUM_EVT-1:0] w_hit;
  logic [NUM_EVT-1:0] r_clr_sel;

  always_comb begin
    w_hit = '0;
    for (int k = 0; k < NUM_EVT; k++) begin
      if (bus.uart_rd_addr == EVT_BASE + 8'(k)) w_hit[k] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_sel <= '0;
    end else if (r_state == S_IDLE && bus.read_req) begin
      r_clr_sel <= w_hit;
    end
  end

  // Clear fires on the same edge that enters ACK, so an aborted read never clears.
  assign w_clr = (r_state == S_WAIT && bus.read_req && r_lat_cnt == 4'd0) ? r_clr_sel : '0;
`else
  assign w_clr = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_lat_cnt <= '0;
      r_snap    <= '0;
      r_status  <= '0;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.read_req) begin
            r_snap    <= w_sel;
            r_lat_cnt <= LAT_LOAD;
            r_busy    <= 1'b1;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!bus.read_req) begin
            r_busy    <= 1'b0;
            r_lat_cnt <= '0;
            r_state   <= S_IDLE;
          end else if (r_lat_cnt == 4'd0) begin
            r_status <= r_snap;
            r_ack    <= 1'b1;
            r_state  <= S_ACK;
          end else begin
            r_lat_cnt <= r_lat_cnt - 4'd1;
          end
        end
        S_ACK: begin
          if (!bus.read_req) begin
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.read_ack   = r_ack;
  assign bus.status_bus = r_status;
  assign bus.rd_busy    = r_busy;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_ips2l_uart_status_responder.sv
// Self-checking bench for ips2l_uart_status_responder (works with or without UART_STATUS_CLR_ON_RD_EN).
module tb_ips2l_uart_status_responder;
  import ips2l_uart_status_pkg::*;

  localparam int          NUM_ST   = 8;
  localparam int          NUM_EVT  = 4;
  localparam int          RD_LAT   = 2;
  localparam logic [31:0] ID_VAL   = 32'h5043_0001;
  localparam logic [31:0] UNMAP    = 32'hDEAD_BEEF;
`ifdef UART_STATUS_CLR_ON_RD_EN
  localparam logic [31:0] REREAD_EXP = 32'd0;
`else
  localparam logic [31:0] REREAD_EXP = 32'd5;
`endif

  // ---------------- clock / reset ----------------
  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NUM_ST*32-1:0] st_in = '0;
  logic [NUM_EVT-1:0]   evt_in = '0;
  rd_state_e            dbg_state;

  always #5 clk = ~clk;

  ips2l_uart_status_responder_if bus ();

  ips2l_uart_status_responder #(
    .NUM_ST (NUM_ST), .NUM_EVT (NUM_EVT), .RD_LAT (RD_LAT),
    .ID_VAL (ID_VAL), .UNMAPPED_VAL (UNMAP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .st_in       (st_in),
    .evt_in      (evt_in),
    .o_dbg_state (dbg_state)
  );

  // ---------------- reference model / scoreboard ----------------
  int          n_pass = 0;
  int          n_total = 0;
  bit          rnd_on = 1'b0;
  logic [31:0] m_st  [NUM_ST];
  logic [31:0] m_cnt [NUM_EVT];
  logic [31:0] exp_q [$];

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] exp;
  } vec_t;
  vec_t vec [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [31:0] ref_read(input logic [7:0] a);
    int ia;
    ia = int'(a);
    if (a == 8'hF0) return ID_VAL;
    if (ia < NUM_ST) return m_st[ia];
    if (ia >= 16 && ia < 16 + NUM_EVT) return m_cnt[ia - 16];
    return UNMAP;
  endfunction

  function automatic int cnt_idx(input logic [7:0] a);
    int ia;
    ia = int'(a);
    if (ia >= 16 && ia < 16 + NUM_EVT) return ia - 16;
    return -1;
  endfunction

  function automatic logic [NUM_EVT-1:0] next_evt();
    if (!rnd_on || $urandom_range(0, 2) != 0) return '0;
    return NUM_EVT'($urandom_range(0, (1 << NUM_EVT) - 1));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_st(input int k, input logic [31:0] v);
    m_st[k] = v;
    st_in[k*32 +: 32] = v;
  endtask

  // One clock: apply event pulses, advance the model the way the counters are defined to behave.
  task automatic step(input logic [NUM_EVT-1:0] evt, input int clr_idx);
    evt_in = evt;
    @(posedge clk);
    for (int i = 0; i < NUM_EVT; i++) begin
      if (i == clr_idx) m_cnt[i] = evt[i] ? 32'd1 : 32'd0;
      else if (evt[i] && m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i] = m_cnt[i] + 32'd1;
    end
    #1;
    evt_in = '0;
  endtask

  task automatic do_read(input logic [7:0] a, input logic [31:0] exp, input int hold);
    int          ci;
    logic [31:0] got;
`ifdef UART_STATUS_CLR_ON_RD_EN
    ci = cnt_idx(a);
`else
    ci = -1;
`endif
    exp_q.push_back(exp);
    bus.read_req     = 1'b1;
    bus.uart_rd_addr = a;
    step(next_evt(), -1);
    chk("busy_capture", 32'(bus.rd_busy), 32'd1);
    for (int k = 1; k <= RD_LAT; k++) begin
      chk("ack_early", 32'(bus.read_ack), 32'd0);
      if (rnd_on && $urandom_range(0, 1) == 1) set_st(int'($urandom_range(0, NUM_ST - 1)), $urandom);
      step(next_evt(), (k == RD_LAT) ? ci : -1);
    end
    got = exp_q.pop_front();
    chk("ack_rise", 32'(bus.read_ack), 32'd1);
    chk("rd_data", bus.status_bus, got);
    for (int h = 0; h < hold; h++) begin
      if (rnd_on) set_st(int'($urandom_range(0, NUM_ST - 1)), $urandom);
      step(next_evt(), -1);
      chk("ack_hold", 32'(bus.read_ack), 32'd1);
      chk("data_hold", bus.status_bus, got);
    end
    bus.read_req     = 1'b0;
    bus.uart_rd_addr = 8'($urandom);
    step(next_evt(), -1);
    chk("ack_fall", 32'(bus.read_ack), 32'd0);
    chk("busy_fall", 32'(bus.rd_busy), 32'd0);
    chk("data_keep", bus.status_bus, got);
  endtask

  task automatic do_abort(input logic [7:0] a);
    bus.read_req     = 1'b1;
    bus.uart_rd_addr = a;
    step(next_evt(), -1);
    chk("abort_busy", 32'(bus.rd_busy), 32'd1);
    bus.read_req = 1'b0;
    step(next_evt(), -1);
    chk("abort_noack", 32'(bus.read_ack), 32'd0);
    chk("abort_busy_low", 32'(bus.rd_busy), 32'd0);
    step(next_evt(), -1);
    chk("abort_noack2", 32'(bus.read_ack), 32'd0);
  endtask

  function automatic logic [7:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 8'($urandom_range(0, NUM_ST - 1));
      1:       return 8'(16 + $urandom_range(0, NUM_EVT - 1));
      2:       return 8'hF0;
      default: return 8'($urandom);
    endcase
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] a;
    bus.read_req     = 1'b0;
    bus.uart_rd_addr = '0;
    for (int k = 0; k < NUM_ST; k++) set_st(k, {8'(k), 24'hA5A5A5});
    set_st(3, 32'h1234_5678);
    for (int i = 0; i < NUM_EVT; i++) m_cnt[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(bus.read_ack), 32'd0);
    chk("rst_data", bus.status_bus, 32'd0);
    chk("rst_busy", 32'(bus.rd_busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    rst_n = 1'b1;
    step('0, -1);

    vec[0] = '{8'h03, 32'h1234_5678};
    vec[1] = '{8'h00, 32'h00A5_A5A5};
    vec[2] = '{8'h07, 32'h07A5_A5A5};
    vec[3] = '{8'h08, UNMAP};
    vec[4] = '{8'hF0, 32'h5043_0001};
    vec[5] = '{8'h42, 32'hDEAD_BEEF};
    vec[6] = '{8'h10, 32'd0};
    vec[7] = '{8'h13, 32'd0};
    vec[8] = '{8'h14, UNMAP};
    vec[9] = '{8'hFF, UNMAP};
    for (int i = 0; i < 10; i++) do_read(vec[i].addr, vec[i].exp, i % 3);

    // five pulses on counter 1, then read and re-read
    for (int i = 0; i < 5; i++) begin
      step(4'b0010, -1);
      step(4'b0000, -1);
    end
    do_read(8'h11, 32'd5, 0);
    do_read(8'h11, REREAD_EXP, 1);

    // saturation from just below full scale
    force dut.g_evt[2].u_cnt.r_cnt = 32'hFFFF_FFFE;
    step('0, -1);
    release dut.g_evt[2].u_cnt.r_cnt;
    m_cnt[2] = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      step(4'b0100, -1);
      step(4'b0000, -1);
    end
    do_read(8'h12, 32'hFFFF_FFFF, 0);

    // abort during WAIT leaves the counter intact, next read is normal
    step(4'b1000, -1);
    step(4'b1000, -1);
    do_abort(8'h13);
    do_read(8'h13, 32'd2, 0);

    // randomized traffic against the model
    rnd_on = 1'b1;
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: begin
          a = pick_addr();
          do_read(a, ref_read(a), int'($urandom_range(0, 2)));
        end
        6: do_abort(pick_addr());
        default: begin
          set_st(int'($urandom_range(0, NUM_ST - 1)), $urandom);
          repeat ($urandom_range(1, 4)) step(next_evt(), -1);
        end
      endcase
    end
    rnd_on = 1'b0;
    for (int i = 0; i < NUM_EVT; i++) begin
      a = 8'(16 + i);
      do_read(a, ref_read(a), 0);
    end

    // make sure counters are nonzero, then reset in the middle of ACK
    step(4'b1111, -1);
    bus.read_req     = 1'b1;
    bus.uart_rd_addr = 8'h03;
    repeat (RD_LAT + 1) step('0, -1);
    chk("pre_rst_ack", 32'(bus.read_ack), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("arst_ack", 32'(bus.read_ack), 32'd0);
    chk("arst_data", bus.status_bus, 32'd0);
    chk("arst_busy", 32'(bus.rd_busy), 32'd0);
    bus.read_req = 1'b0;
    for (int i = 0; i < NUM_EVT; i++) m_cnt[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NUM_EVT; i++) do_read(8'(16 + i), 32'd0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
